spm_seq_driver: RTL
===================

Name: spm_seq_driver

Overview:
- Operand driver and product collector for the serial-parallel multiplier (spm) core. Drives the core's inputs and collects its output.
- Accepts a parallel signed x/y pair over a valid/ready handshake.
- Holds x parallel on the core, shifts y into the core LSB-first with sign extension, then deserialises the core's serial product p into a 2*WIDTH-bit parallel result.
- Sits between the system bus-side register file and the spm instance; it is the feed/collect end of the core's serial y/p interface.

Parameters:
- WIDTH, 32, operand width in bits; the core multiplies WIDTH x WIDTH into 2*WIDTH.
- P_LAT, 1, cycles from a y bit entering the core to the matching p bit appearing at the core output.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  driver idle and able to accept operands.
- in_x  input  WIDTH  multiplicand, two's complement.
- in_y  input  WIDTH  multiplier, two's complement.
- spm_rst  output  1  clear to the spm core; active-high, driven from a register.
- spm_x  output  WIDTH  parallel x to the core, held for the whole operation.
- spm_y  output  1  serial y bit to the core.
- spm_p  input  1  serial product bit from the core.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- out_p  output  2*WIDTH  assembled product.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - FSM goes to IDLE, counters are 0.
  - in_ready=1, out_valid=0, out_p=0, spm_x=0, spm_y=0, spm_rst=1.
- FSM states are IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - in_ready=1 and spm_rst=0.
  - An accept is in_valid & in_ready. On accept, latch in_x into spm_x, latch in_y into a shift register, then go to CLR.
- CLR:
  - Exactly one cycle with spm_rst=1, flushing the core's carry-save state.
  - in_ready=0. Go to SHIFT with cnt=0.
- SHIFT: lasts 2*WIDTH cycles, cnt runs 0..2*WIDTH-1.
  - spm_y = y_sr[0]. The shift register shifts right with arithmetic fill, so cycles WIDTH..2*WIDTH-1 repeat in_y's MSB (sign extension).
  - spm_p is captured starting P_LAT cycles after the first SHIFT cycle. Each capture shifts right into the product register, MSB-in, so the first captured bit ends up at out_p[0].
- DRAIN:
  - Lasts P_LAT cycles with spm_y=0, collecting the remaining P_LAT product bits.
  - Exactly 2*WIDTH bits are captured in total. Go to DONE.
- DONE:
  - out_valid=1 and out_p stable until out_valid & out_ready, then return to IDLE.
  - out_p keeps its value after the handshake until the next capture overwrites it.
- Latency from accept to out_valid is 1 + 2*WIDTH + P_LAT cycles. The driver is non-pipelined: only one operation is in flight.
- Arithmetic: out_p = sign-extended in_x times sign-extended in_y, truncated to 2*WIDTH bits. The product is exact for all operands, including -2^(WIDTH-1) squared.
- Boundary conditions:
  - in_valid asserted while busy: ignored, since in_ready=0. Operands must be held by the source.
  - out_ready held low: remain in DONE indefinitely with no loss of data.
  - out_ready already high when DONE is entered: handshake completes that cycle; a new accept is possible the following cycle in IDLE.
  - rst asserted mid-operation: immediate abort with all outputs at their reset values; the partial product is discarded.
- spm_rst, spm_x and spm_y are all register outputs, so there are no combinational paths from spm_p to outputs.

Optional Feature:
- Macro: SPM_SEQ_DRIVER_CHECK_EN.
- With the macro:
  - On accept, latch a reference product computed behaviourally with the * operator.
  - In DONE, compare it against out_p.
  - Add output chk_err (1 bit, reset 0), which is sticky until rst and set in the first DONE cycle on mismatch.
  - Add a simulation-only assertion that fires on that mismatch.
- Without the macro: no chk_err port, no reference register, no comparison logic.

Decomposition:
- Package spm_seq_pkg contains:
  - the state enum (IDLE, CLR, SHIFT, DRAIN, DONE);
  - localparam helpers CNT_W = $clog2(2*WIDTH+P_LAT+1) and PROD_W = 2*WIDTH.
- One sub-module, spm_seq_sipo: a serial-in parallel-out capture register with a shift enable and a count-done flag. It is reused for product collection.
- The operand shift register stays inline.

Test Plan:
- WIDTH=8, x=3, y=5, out_ready=1:
  - out_p=0x000F;
  - out_valid rises exactly 1+16+P_LAT cycles after accept.
- x=0xFE (-2), y=3: out_p=0xFFFA.
- x=0x80, y=0x80 (-128*-128): out_p=0x4000. x=0x7F, y=0x80: out_p=0xC080.
- Back-to-back:
  - two operand pairs with out_ready held low 5 cycles on the first;
  - first result is held stable and in_ready stays 0 until the handshake;
  - second result is correct, with no bit from the first.
- rst pulse in the 6th SHIFT cycle:
  - all outputs return to reset values in the same cycle;
  - the next operation x=7, y=-1 yields 0xFFF9.
- With SPM_SEQ_DRIVER_CHECK_EN and a forced spm_p stuck-at-0 on a nonzero product: chk_err=1 in the DONE cycle and stays 1 until rst.

Source files
------------

// File: rtl/spm_seq_pkg.sv
// Shared types and sizing helpers for the spm operand driver / product collector.
package spm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  // Counter spans SHIFT and DRAIN back to back, so it must reach 2*WIDTH+P_LAT.
  function automatic int cnt_w(input int width, input int p_lat);
    return $clog2(2 * width + p_lat + 1);
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/spm_seq_sipo.sv
// Serial-in parallel-out capture register: LSB-first stream enters at the MSB and
// shifts right, so after N captures the first bit sits at data_o[0].
module spm_seq_sipo #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [N-1:0] data_o,
  output logic         last_o
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  data_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
    end else if (en_i) begin
      data_q <= {bit_i, data_q[N-1:1]};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // High on the capture that completes the word.
  assign last_o = en_i && (cnt_q == CW'(N - 1));
  assign data_o = data_q;

endmodule

// File: rtl/spm_seq_driver.sv
// Operand driver / product collector for the serial-parallel multiplier core.
// Optional self-check against a behavioural product: define SPM_SEQ_DRIVER_CHECK_EN.
module spm_seq_driver
  import spm_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int P_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 spm_rst,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  input  logic                 spm_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
`ifdef SPM_SEQ_DRIVER_CHECK_EN
  ,
  output logic                 chk_err
`endif
);

  localparam int CNT_W  = cnt_w(WIDTH, P_LAT);
  localparam int PROD_W = prod_w(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_sr_q, y_sr_d;
  logic [WIDTH-1:0] spm_x_q, spm_x_d;
  logic             spm_y_q, spm_y_d;
  logic             spm_rst_q, spm_rst_d;

  logic             accept;
  logic             cap_en;
  logic             cap_last;

  assign accept = in_valid && (state_q == IDLE);
  // Product bits lag the y stream by P_LAT cycles; the shared counter covers both phases.
  assign cap_en = ((state_q == SHIFT) || (state_q == DRAIN)) && (cnt_q >= CNT_W'(P_LAT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_sr_d  = y_sr_q;
    spm_x_d = spm_x_q;
    spm_y_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          spm_x_d = in_x;
          y_sr_d  = in_y;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        spm_y_d = y_sr_q[0];
        y_sr_d  = {y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cap_last) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(2 * WIDTH - 1)) begin
          state_d = DRAIN;
        end else begin
          // Arithmetic fill: the upper WIDTH cycles repeat the sign bit.
          spm_y_d = y_sr_q[0];
          y_sr_d  = {y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cap_last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    spm_rst_d = (state_d == CLR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      y_sr_q    <= '0;
      spm_x_q   <= '0;
      spm_y_q   <= 1'b0;
      spm_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_sr_q    <= y_sr_d;
      spm_x_q   <= spm_x_d;
      spm_y_q   <= spm_y_d;
      spm_rst_q <= spm_rst_d;
    end
  end

  spm_seq_sipo #(.N(PROD_W)) u_sipo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == CLR),
    .en_i   (cap_en),
    .bit_i  (spm_p),
    .data_o (out_p),
    .last_o (cap_last)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign spm_x     = spm_x_q;
  assign spm_y     = spm_y_q;
  assign spm_rst   = spm_rst_q;

`ifdef SPM_SEQ_DRIVER_CHECK_EN
  logic [PROD_W-1:0] ref_q;
  logic              chk_err_q;
  logic              mismatch;

  assign mismatch = (state_q == DONE) && (out_p != ref_q);
  // Flag is visible in the very DONE cycle that mismatches, then held sticky.
  assign chk_err  = chk_err_q || mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (accept)
        ref_q <= PROD_W'($signed({{WIDTH{in_x[WIDTH-1]}}, in_x}) *
                         $signed({{WIDTH{in_y[WIDTH-1]}}, in_y}));
      if (mismatch) chk_err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE)
      assert (out_p == ref_q) else $error("spm_seq_driver: product mismatch");
  end
`endif
`endif

endmodule
